// File: rtl/block_aligner.sv
// 66-bit block aligner: extracts blocks from the gearbox buffer at the
// seeker offset, tracks sync headers and maintains block lock.
module block_aligner #(
  parameter logic [5:0] SKIP_CNT = 6'd32,
  parameter int         LOCK_CNT = 64,
  parameter int         WIN_LEN  = 64,
  parameter int         ERR_MAX  = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [193:0] gbox_buffer,
  input  logic [5:0]   gbox_cnt,
  input  logic         buffer_dv,
  input  logic         is_synced,
  input  logic [6:0]   offset_pos,
  output logic [63:0]  blk_data_o,
  output logic [1:0]   blk_hdr_o,
  output logic         blk_valid_o,
  output logic         lock_o,
  output logic [15:0]  err_cnt_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;
  logic [15:0]   err_q, err_d;
  logic [6:0]    off_q, off_d;
  logic [63:0]   data_q, data_d;
  logic [1:0]    hdr_q, hdr_d;
  logic          vld_q, vld_d;

  logic          sync_ok;
  logic [6:0]    off_sel;
  logic [65:0]   blk;
  logic          hdr_ok;
  logic          blk_ev;
  logic          off_chg;
  logic [GW-1:0] good_inc;
  logic [WW-1:0] win_inc;
  logic [EW-1:0] werr_inc;

  // Out-of-range offsets behave as loss of sync.
  assign sync_ok  = is_synced && (offset_pos <= 7'd65);
  assign off_sel  = sync_ok ? offset_pos : 7'd0;
  assign blk      = 66'(gbox_buffer >> off_sel);
  assign hdr_ok   = (blk[1:0] == 2'b01) || (blk[1:0] == 2'b10);
  assign blk_ev   = buffer_dv && sync_ok && (gbox_cnt != SKIP_CNT);
  assign off_chg  = offset_pos != off_q;
  assign good_inc = good_q + GW'(1);
  assign win_inc  = win_q + WW'(1);
  assign werr_inc = werr_q + EW'(!hdr_ok);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = err_q;
    off_d   = off_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    vld_d   = 1'b0;
    if (buffer_dv) begin
      if (!sync_ok) begin
        state_d = UNSYNC;
      end else begin
        off_d = offset_pos;
        if (state_q != UNSYNC && blk_ev) begin
          vld_d  = 1'b1;
          data_d = blk[65:2];
          hdr_d  = blk[1:0];
        end
        unique case (state_q)
          UNSYNC: begin
            state_d = CHECK;
            good_d  = '0;
          end
          CHECK: begin
            if (off_chg) begin
              good_d = '0;
            end else if (blk_ev) begin
              if (!hdr_ok) begin
                good_d = '0;
              end else if (good_inc == GW'(LOCK_CNT)) begin
                state_d = LOCKED;
                good_d  = '0;
                win_d   = '0;
                werr_d  = '0;
              end else begin
                good_d = good_inc;
              end
            end
          end
          LOCKED: begin
            if (off_chg) begin
              state_d = CHECK;
              good_d  = '0;
            end else if (blk_ev) begin
              if (!hdr_ok && err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
              end
              // Too many errors wins over a window wrap on the same block.
              if (werr_inc == EW'(ERR_MAX)) begin
                state_d = CHECK;
                good_d  = '0;
                win_d   = '0;
                werr_d  = '0;
              end else if (win_inc == WW'(WIN_LEN)) begin
                win_d  = '0;
                werr_d = '0;
              end else begin
                win_d  = win_inc;
                werr_d = werr_inc;
              end
            end
          end
          default: begin
            state_d = UNSYNC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNSYNC;
      good_q  <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      off_q   <= '0;
      data_q  <= '0;
      hdr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      off_q   <= off_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      vld_q   <= vld_d;
    end
  end

  assign blk_data_o  = data_q;
  assign blk_hdr_o   = hdr_q;
  assign blk_valid_o = vld_q;
  assign lock_o      = (state_q == LOCKED);
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_block_aligner.sv
// Directed self-checking bench for block_aligner.
module tb_block_aligner;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic         is_synced;
  logic [6:0]   offset_pos;
  logic [63:0]  blk_data_o;
  logic [1:0]   blk_hdr_o;
  logic         blk_valid_o;
  logic         lock_o;
  logic [15:0]  err_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int seq   = 0;

  always #5 clk_i = ~clk_i;

  block_aligner dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .gbox_buffer (gbox_buffer),
    .gbox_cnt    (gbox_cnt),
    .buffer_dv   (buffer_dv),
    .is_synced   (is_synced),
    .offset_pos  (offset_pos),
    .blk_data_o  (blk_data_o),
    .blk_hdr_o   (blk_hdr_o),
    .blk_valid_o (blk_valid_o),
    .lock_o      (lock_o),
    .err_cnt_o   (err_cnt_o)
  );

  function automatic logic [63:0] pl(input int n);
    logic [31:0] u;
    u = n;
    return 64'h0123_4567_89AB_CDEF ^ {u, ~u};
  endfunction

  function automatic logic [193:0] mkbuf(input logic [6:0] off,
                                         input logic [1:0] hdr,
                                         input logic [63:0] p);
    logic [193:0] b;
    b = {2'b10, {3{64'hF0F0_5A5A_3C3C_9696}}};
    if (off <= 7'd65) b[off +: 66] = {p, hdr};
    return b;
  endfunction

  task automatic cyc(input logic dv, input logic sy,
                     input logic [6:0] off, input logic [5:0] cnt,
                     input logic [1:0] hdr, input logic [63:0] p);
    buffer_dv   = dv;
    is_synced   = sy;
    offset_pos  = off;
    gbox_cnt    = cnt;
    gbox_buffer = mkbuf(off, hdr, p);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    buffer_dv   = 1'b0;
    is_synced   = 1'b0;
    offset_pos  = '0;
    gbox_cnt    = '0;
    gbox_buffer = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic lock_up(input logic [6:0] off);
    do_reset();
    cyc(1, 1, off, 6'd1, 2'b01, 64'd0);
    repeat (64) begin
      cyc(1, 1, off, 6'd1, 2'b01, pl(seq));
      seq++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL rst_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    if (lock_o !== 1'b0) begin
      $display("FAIL rst_lock got=%b exp=0", lock_o); n_err++;
    end
    if (blk_data_o !== 64'd0) begin
      $display("FAIL rst_data got=%h exp=0", blk_data_o); n_err++;
    end
    if (blk_hdr_o !== 2'd0) begin
      $display("FAIL rst_hdr got=%b exp=0", blk_hdr_o); n_err++;
    end
    if (err_cnt_o !== 16'd0) begin
      $display("FAIL rst_err got=%0d exp=0", err_cnt_o); n_err++;
    end
  endtask

  task automatic test_lock();
    int nv;
    logic ev;
    logic [5:0] g;
    do_reset();
    nv = 0;
    for (int k = 0; k < 80; k++) begin
      g = 6'(k % 33);
      cyc(1, 1, 7'd7, g, 2'b01, pl(k));
      ev = (k != 0) && (g != 6'd32);
      if (ev) nv++;
      n_cmp += 2;
      if (blk_valid_o !== ev) begin
        $display("FAIL lock_valid k=%0d got=%b exp=%b", k, blk_valid_o, ev);
        n_err++;
      end
      if (lock_o !== (nv >= 64)) begin
        $display("FAIL lock_rise k=%0d got=%b exp=%b", k, lock_o, nv >= 64);
        n_err++;
      end
      if (ev) begin
        n_cmp += 2;
        if (blk_data_o !== pl(k)) begin
          $display("FAIL lock_data k=%0d got=%h exp=%h", k, blk_data_o, pl(k));
          n_err++;
        end
        if (blk_hdr_o !== 2'b01) begin
          $display("FAIL lock_hdr k=%0d got=%b exp=01", k, blk_hdr_o);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_check_reset();
    do_reset();
    cyc(1, 1, 7'd7, 6'd1, 2'b01, 64'd0);
    for (int i = 0; i < 40; i++)
      cyc(1, 1, 7'd7, 6'd1, (i % 2) ? 2'b10 : 2'b01, pl(i));
    cyc(1, 1, 7'd7, 6'd1, 2'b00, pl(99));
    n_cmp += 2;
    if (blk_hdr_o !== 2'b00) begin
      $display("FAIL chk_badhdr got=%b exp=00", blk_hdr_o); n_err++;
    end
    if (lock_o !== 1'b0) begin
      $display("FAIL chk_nolock0 got=%b exp=0", lock_o); n_err++;
    end
    for (int i = 0; i < 63; i++)
      cyc(1, 1, 7'd7, 6'd1, (i % 3 == 0) ? 2'b10 : 2'b01, pl(i));
    n_cmp++;
    if (lock_o !== 1'b0) begin
      $display("FAIL chk_nolock63 got=%b exp=0", lock_o); n_err++;
    end
    cyc(1, 1, 7'd7, 6'd1, 2'b10, pl(7));
    n_cmp++;
    if (lock_o !== 1'b1) begin
      $display("FAIL chk_lock64 got=%b exp=1", lock_o); n_err++;
    end
  endtask

  task automatic test_loss();
    lock_up(7'd7);
    n_cmp++;
    if (lock_o !== 1'b1) begin
      $display("FAIL loss_locked got=%b exp=1", lock_o); n_err++;
    end
    repeat (10) cyc(1, 1, 7'd7, 6'd1, 2'b01, pl(1));
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 7'd7, 6'd1, 2'b11, pl(i));
      n_cmp++;
      if (lock_o !== (i < 15)) begin
        $display("FAIL loss_lock i=%0d got=%b exp=%b", i, lock_o, i < 15);
        n_err++;
      end
    end
    n_cmp += 3;
    if (err_cnt_o !== 16'd16) begin
      $display("FAIL loss_err got=%0d exp=16", err_cnt_o); n_err++;
    end
    if (blk_valid_o !== 1'b1) begin
      $display("FAIL loss_valid got=%b exp=1", blk_valid_o); n_err++;
    end
    if (blk_hdr_o !== 2'b11) begin
      $display("FAIL loss_hdr got=%b exp=11", blk_hdr_o); n_err++;
    end
  endtask

  task automatic test_windows();
    lock_up(7'd7);
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < 64; j++)
        cyc(1, 1, 7'd7, 6'd1, (j < 15) ? 2'b11 : 2'b01, pl(j));
      n_cmp++;
      if (lock_o !== 1'b1) begin
        $display("FAIL win_lock w=%0d got=%b exp=1", w, lock_o); n_err++;
      end
    end
    n_cmp++;
    if (err_cnt_o !== 16'd45) begin
      $display("FAIL win_err got=%0d exp=45", err_cnt_o); n_err++;
    end
  endtask

  task automatic test_offset();
    lock_up(7'd7);
    cyc(1, 1, 7'd40, 6'd1, 2'b01, pl(500));
    n_cmp += 3;
    if (lock_o !== 1'b0) begin
      $display("FAIL off_drop got=%b exp=0", lock_o); n_err++;
    end
    if (blk_valid_o !== 1'b1) begin
      $display("FAIL off_valid got=%b exp=1", blk_valid_o); n_err++;
    end
    if (blk_data_o !== pl(500)) begin
      $display("FAIL off_data got=%h exp=%h", blk_data_o, pl(500)); n_err++;
    end
    repeat (63) cyc(1, 1, 7'd40, 6'd1, 2'b01, pl(3));
    n_cmp++;
    if (lock_o !== 1'b0) begin
      $display("FAIL off_early got=%b exp=0", lock_o); n_err++;
    end
    cyc(1, 1, 7'd40, 6'd1, 2'b01, pl(4));
    n_cmp++;
    if (lock_o !== 1'b1) begin
      $display("FAIL off_relock got=%b exp=1", lock_o); n_err++;
    end
  endtask

  task automatic test_sync_drop();
    lock_up(7'd7);
    cyc(1, 0, 7'd7, 6'd1, 2'b11, pl(600));
    n_cmp += 3;
    if (lock_o !== 1'b0) begin
      $display("FAIL drop_lock got=%b exp=0", lock_o); n_err++;
    end
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL drop_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    if (err_cnt_o !== 16'd0) begin
      $display("FAIL drop_err got=%0d exp=0", err_cnt_o); n_err++;
    end
    cyc(1, 1, 7'd70, 6'd1, 2'b01, pl(601));
    n_cmp++;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL badoff_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    cyc(1, 1, 7'd7, 6'd1, 2'b01, pl(602));
    n_cmp++;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL resync_first got=%b exp=0", blk_valid_o); n_err++;
    end
    cyc(1, 1, 7'd7, 6'd1, 2'b01, pl(603));
    n_cmp += 2;
    if (blk_valid_o !== 1'b1) begin
      $display("FAIL resync_valid got=%b exp=1", blk_valid_o); n_err++;
    end
    if (blk_data_o !== pl(603)) begin
      $display("FAIL resync_data got=%h exp=%h", blk_data_o, pl(603)); n_err++;
    end
  endtask

  task automatic test_hold();
    cyc(0, 1, 7'd7, 6'd1, 2'b10, pl(700));
    n_cmp += 3;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL hold_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    if (blk_data_o !== pl(603)) begin
      $display("FAIL hold_data got=%h exp=%h", blk_data_o, pl(603)); n_err++;
    end
    if (blk_hdr_o !== 2'b01) begin
      $display("FAIL hold_hdr got=%b exp=01", blk_hdr_o); n_err++;
    end
    cyc(1, 1, 7'd7, 6'd32, 2'b10, pl(701));
    n_cmp += 2;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL skip_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    if (blk_data_o !== pl(603)) begin
      $display("FAIL skip_data got=%h exp=%h", blk_data_o, pl(603)); n_err++;
    end
  endtask

  task automatic test_async_reset();
    lock_up(7'd7);
    repeat (5) cyc(1, 1, 7'd7, 6'd1, 2'b11, pl(800));
    #3;
    rst_ni = 1'b0;
    #1;
    n_cmp += 5;
    if (lock_o !== 1'b0) begin
      $display("FAIL arst_lock got=%b exp=0", lock_o); n_err++;
    end
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL arst_valid got=%b exp=0", blk_valid_o); n_err++;
    end
    if (blk_data_o !== 64'd0) begin
      $display("FAIL arst_data got=%h exp=0", blk_data_o); n_err++;
    end
    if (blk_hdr_o !== 2'd0) begin
      $display("FAIL arst_hdr got=%b exp=0", blk_hdr_o); n_err++;
    end
    if (err_cnt_o !== 16'd0) begin
      $display("FAIL arst_err got=%0d exp=0", err_cnt_o); n_err++;
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc(1, 1, 7'd7, 6'd1, 2'b01, pl(801));
    n_cmp++;
    if (blk_valid_o !== 1'b0) begin
      $display("FAIL arst_first got=%b exp=0", blk_valid_o); n_err++;
    end
    cyc(1, 1, 7'd7, 6'd1, 2'b01, pl(802));
    n_cmp += 2;
    if (blk_valid_o !== 1'b1) begin
      $display("FAIL arst_resume got=%b exp=1", blk_valid_o); n_err++;
    end
    if (lock_o !== 1'b0) begin
      $display("FAIL arst_nolock got=%b exp=0", lock_o); n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_check_reset();
    test_loss();
    test_windows();
    test_offset();
    test_sync_drop();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
